translate_out: RTL and testbench
================================

// Module: translate_out
// PURPOSE
//  Converts one sprite-ROM word (local pixel offset + colour + draw flag) into an absolute
//  VGA-adapter pixel write. Sits between the sprite memory read port and the VGA adapter
//  (x/y/colour/writeEn) inside each sprite wrapper; the sprite origin is x_coord/y_coord.
//  One word in per clock, one registered pixel out per clock; off-screen pixels are suppressed.
// PARAMETERS
//  SCREEN_W   160  visible width; pixels with abs x >= SCREEN_W are not written
//  SCREEN_H   120  visible height; pixels with abs y >= SCREEN_H are not written
//  XOFF_W     6    width of x-offset field in the sprite word
//  YOFF_W     6    width of y-offset field in the sprite word
// PORTS
//  clock     in   1   system clock (CLOCK_50); all state on posedge
//  reset     in   1   synchronous, active-high reset
//  out       in   16  sprite word: [15:10] x offset, [9:4] y offset, [3:1] colour, [0] draw flag
//  x_coord   in   8   sprite origin x (top-left)
//  y_coord   in   7   sprite origin y (top-left)
//  x         out  8   absolute pixel x
//  y         out  7   absolute pixel y
//  colour    out  3   pixel colour {R,G,B}
//  writeEn   out  1   pixel write strobe to VGA adapter
// BEHAVIOUR
//  - Reset (reset=1 at posedge): x=0, y=0, colour=0, writeEn=0 on the next cycle; overrides all.
//  - Latency: exactly 1 clock; inputs sampled at posedge N appear on outputs after posedge N.
//    No handshake/backpressure; every cycle produces a new result.
//  - Field decode: xo=out[15:10], yo=out[9:4], c=out[3:1], draw=out[0].
//  - Arithmetic: sx = {1'b0,x_coord}+xo (9 bits), sy = {1'b0,y_coord}+yo (8 bits), both
//    zero-extended, unsigned, no saturation.
//  - Outputs: x=sx[7:0], y=sy[6:0], colour=c (registered regardless of draw flag).
//  - writeEn = draw & (sx < SCREEN_W) & (sy < SCREEN_H). Carry out of the 8/7-bit sum counts as
//    off-screen (never wraps to the left/top edge).
//  - draw=0 -> writeEn=0 (transparent pixel); x/y/colour still update.
//  - Origin changes mid-sprite take effect on the very next word; no latching of x_coord/y_coord.
//  - Reset deasserted mid-stream: first word sampled after reset produces valid output 1 cycle later.
// STRUCTURE
//  - Shared package: SCREEN_W/SCREEN_H constants and the sprite-word field positions
//    (XOFF_MSB/LSB, YOFF_MSB/LSB, COL_MSB/LSB, DRAW_BIT) reused by all sprite wrappers.
//  - Single flat module; one combinational decode/add/clip stage feeding one output register bank.
//    No sub-modules required.
// TESTING
//  1 reset=1 with out=16'hFFFF -> x=0,y=0,colour=0,writeEn=0 after posedge; stays while reset=1.
//  2 x_coord=10,y_coord=20,out={6'd5,6'd3,3'b101,1'b1} -> next cycle x=15,y=23,colour=5,writeEn=1.
//  3 same as 2 with out[0]=0 -> x=15,y=23,colour=5,writeEn=0.
//  4 x_coord=158,xo=2 (sx=160) -> writeEn=0; xo=1 (sx=159) -> writeEn=1 (right-edge clip).
//  5 y_coord=127,yo=1 -> y=0 (wrapped low bits), writeEn=0 (bottom clip, no wrap to row 0).
//  6 stream 4 words back-to-back with changing x_coord -> each output follows its input by exactly 1 cycle.

Source files
------------

// File: rtl/translate_out_pkg.sv
// rtl/translate_out_pkg.sv - screen limits and sprite-word field layout shared by sprite wrappers
//
// Purpose: shared constants for translating sprite-ROM words into VGA pixel writes.
//   SCREEN_W / SCREEN_H : visible area; sized to match the 9-bit / 8-bit sums they are compared to
//   XOFF_* / YOFF_*     : x / y offset fields of the sprite word
//   COL_* / DRAW_BIT    : colour field and draw (non-transparent) flag
package translate_out_pkg;

    localparam int XOFF_W = 6;
    localparam int YOFF_W = 6;

    localparam logic [8:0] SCREEN_W = 9'd160;
    localparam logic [7:0] SCREEN_H = 8'd120;

    localparam int XOFF_MSB = 15;
    localparam int XOFF_LSB = 10;
    localparam int YOFF_MSB = 9;
    localparam int YOFF_LSB = 4;
    localparam int COL_MSB  = 3;
    localparam int COL_LSB  = 1;
    localparam int DRAW_BIT = 0;

endpackage

// File: rtl/translate_out.sv
// rtl/translate_out.sv - sprite word to absolute VGA pixel write, one registered pixel per clock
//
// Purpose: decode offset/colour/draw from a sprite word, add the sprite origin, clip against
//   the visible screen and register the resulting pixel write (latency 1, no backpressure).
// Ports:
//   clock    in   system clock, all state on posedge
//   reset    in   synchronous active-high reset
//   out      in   [15:0] sprite word {xo[5:0], yo[5:0], colour[2:0], draw}
//   x_coord  in   [7:0] sprite origin x
//   y_coord  in   [6:0] sprite origin y
//   x        out  [7:0] absolute pixel x
//   y        out  [6:0] absolute pixel y
//   colour   out  [2:0] pixel colour {R,G,B}
//   writeEn  out  pixel write strobe
module translate_out
    import translate_out_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] out,
    input  logic [7:0]  x_coord,
    input  logic [6:0]  y_coord,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        writeEn
);

    logic [XOFF_W-1:0] xo;
    logic [YOFF_W-1:0] yo;
    logic [2:0]        col;
    logic              draw;

    // One extra bit on each sum so a carry is seen as off-screen rather than wrapping.
    logic [8:0] sx;
    logic [7:0] sy;

    logic [7:0] x_d, x_q;
    logic [6:0] y_d, y_q;
    logic [2:0] colour_d, colour_q;
    logic       we_d, we_q;

    always_comb begin
        xo   = out[XOFF_MSB:XOFF_LSB];
        yo   = out[YOFF_MSB:YOFF_LSB];
        col  = out[COL_MSB:COL_LSB];
        draw = out[DRAW_BIT];

        sx = {1'b0, x_coord} + {3'b000, xo};
        sy = {1'b0, y_coord} + {2'b00, yo};

        x_d      = sx[7:0];
        y_d      = sy[6:0];
        colour_d = col;
        we_d     = draw & (sx < SCREEN_W) & (sy < SCREEN_H);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            we_q     <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            we_q     <= we_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign writeEn = we_q;

endmodule

// File: tb/tb_translate_out.sv
// tb/tb_translate_out.sv - self-checking bench for translate_out
module tb_translate_out;

    logic        clock;
    logic        reset;
    logic [15:0] out_w;
    logic [7:0]  x_coord;
    logic [6:0]  y_coord;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        writeEn;

    int total = 0;
    int bad   = 0;

    translate_out dut (
        .clock   (clock),
        .reset   (reset),
        .out     (out_w),
        .x_coord (x_coord),
        .y_coord (y_coord),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .writeEn (writeEn)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: packed {writeEn, colour[2:0], y[6:0], x[7:0]} computed with plain integers.
    function automatic logic [18:0] ref_pixel(input logic rst, input logic [15:0] w,
                                              input logic [7:0] xc, input logic [6:0] yc);
        int ax, ay, c, d, we;
        if (rst) return 19'd0;
        ax = int'(xc) + int'(w[15:10]);
        ay = int'(yc) + int'(w[9:4]);
        c  = int'(w[3:1]);
        d  = int'(w[0]);
        we = (d == 1 && ax < 160 && ay < 120) ? 1 : 0;
        return {1'(we), 3'(c), 7'(ay % 128), 8'(ax % 256)};
    endfunction

    logic [18:0] m_q;
    logic        m_valid = 1'b0;

    always @(posedge clock) begin
        m_q     <= ref_pixel(reset, out_w, x_coord, y_coord);
        m_valid <= 1'b1;
    end

    // Every cycle once the model holds a value: DUT outputs must equal the model.
    always @(negedge clock) begin
        if (m_valid) begin
            total = total + 1;
            if ({writeEn, colour, y, x} !== m_q) begin
                bad = bad + 1;
                $display("FAIL model_cmp t=%0t got x=%0d y=%0d c=%0d we=%0d expected x=%0d y=%0d c=%0d we=%0d",
                         $time, x, y, colour, writeEn, m_q[7:0], m_q[14:8], m_q[17:15], m_q[18]);
            end
        end
    end

    task automatic apply(input logic rst, input logic [15:0] w,
                         input logic [7:0] xc, input logic [6:0] yc);
        reset   = rst;
        out_w   = w;
        x_coord = xc;
        y_coord = yc;
        @(posedge clock);
        #1;
    endtask

    task automatic check_lit(input string name, input int ex, input int ey,
                             input int ec, input int ewe);
        total = total + 1;
        if (int'(x) != ex || int'(y) != ey || int'(colour) != ec || int'(writeEn) != ewe) begin
            bad = bad + 1;
            $display("FAIL %s got x=%0d y=%0d c=%0d we=%0d expected x=%0d y=%0d c=%0d we=%0d",
                     name, x, y, colour, writeEn, ex, ey, ec, ewe);
        end
    endtask

    function automatic logic [15:0] word(input int xo, input int yo, input int c, input int d);
        return {6'(xo), 6'(yo), 3'(c), 1'(d)};
    endfunction

    initial begin
        reset = 1'b1; out_w = 16'hFFFF; x_coord = 8'd0; y_coord = 7'd0;

        apply(1'b1, 16'hFFFF, 8'd200, 7'd100);
        check_lit("reset_a", 0, 0, 0, 0);
        apply(1'b1, 16'hFFFF, 8'd10, 7'd10);
        check_lit("reset_b", 0, 0, 0, 0);

        apply(1'b0, word(5, 3, 5, 1), 8'd10, 7'd20);
        check_lit("basic_draw", 15, 23, 5, 1);
        apply(1'b0, word(5, 3, 5, 0), 8'd10, 7'd20);
        check_lit("transparent", 15, 23, 5, 0);

        apply(1'b0, word(2, 0, 3, 1), 8'd158, 7'd0);
        check_lit("right_clip", 160, 0, 3, 0);
        apply(1'b0, word(1, 0, 3, 1), 8'd158, 7'd0);
        check_lit("right_edge", 159, 0, 3, 1);
        apply(1'b0, word(0, 1, 6, 1), 8'd0, 7'd127);
        check_lit("bottom_wrap", 0, 0, 6, 0);
        apply(1'b0, word(0, 1, 6, 1), 8'd0, 7'd118);
        check_lit("bottom_edge", 0, 119, 6, 1);
        apply(1'b0, word(0, 2, 6, 1), 8'd0, 7'd118);
        check_lit("bottom_clip", 0, 120, 6, 0);
        apply(1'b0, word(63, 0, 1, 1), 8'd255, 7'd0);
        check_lit("x_carry", 62, 0, 1, 0);

        for (int i = 0; i < 4; i++) begin
            apply(1'b0, word(i, i, i, 1), 8'(i * 40), 7'd10);
            check_lit($sformatf("stream_%0d", i), i * 40 + i, 10 + i, i, 1);
        end

        // Reset mid-stream, then the first word afterwards must come through.
        apply(1'b1, word(4, 4, 7, 1), 8'd50, 7'd50);
        check_lit("mid_reset", 0, 0, 0, 0);
        apply(1'b0, word(4, 4, 7, 1), 8'd50, 7'd50);
        check_lit("post_reset", 54, 54, 7, 1);

        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 31) == 0), 16'($urandom),
                  8'($urandom), 7'($urandom));
        end

        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
